// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, visible window,
// frame tick, and a one-pixel-delayed blanked colour/sync pin stage.
module vga_timing_gen #(
  parameter int CLK_DIV = 4,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        bright,
  output logic        pix_en,
  output logic        frame_tick,
  input  logic [11:0] rgb_in,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        hSync,
  output logic        vSync
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VS   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VE   = 10'(H_SYNC + H_BP + H_VIS - 1);
  localparam logic [9:0] V_VS   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VE   = 10'(V_SYNC + V_BP + V_VIS - 1);
  localparam logic [9:0] H_SW   = 10'(H_SYNC);
  localparam logic [9:0] V_SW   = 10'(V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic [3:0]    r_q, r_d;
  logic [3:0]    g_q, g_d;
  logic [3:0]    b_q, b_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          tick_q, tick_d;
  logic          h_wrap, v_wrap;
  logic          h_vis, v_vis;
  logic          pe, vis;

  always_comb begin
    pe     = (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_vis  = (h_q >= H_VS) && (h_q <= H_VE);
    v_vis  = (v_q >= V_VS) && (v_q <= V_VE);
    vis    = h_vis && v_vis;

    div_d  = pe ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    tick_d = pe && h_wrap && v_wrap;

    if (pe) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end
      // Pins show the pixel the counters just left, colour forced to 0 in blanking.
      r_d  = vis ? rgb_in[11:8] : 4'h0;
      g_d  = vis ? rgb_in[7:4]  : 4'h0;
      b_d  = vis ? rgb_in[3:0]  : 4'h0;
      hs_d = (h_q >= H_SW);
      vs_d = (v_q >= V_SW);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      h_q    <= '0;
      v_q    <= '0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign hCount     = h_q;
  assign vCount     = v_q;
  assign bright     = vis;
  assign pix_en     = pe;
  assign frame_tick = tick_q;
  assign vgaR       = r_q;
  assign vgaG       = g_q;
  assign vgaB       = b_q;
  assign hSync      = hs_q;
  assign vSync      = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: arithmetic reference
// model from elapsed clocks, position table, and reset sequences.
module tb_vga_timing_gen;

  localparam int CD   = 2;
  localparam int HS   = 4;
  localparam int HBP  = 3;
  localparam int HV   = 8;
  localparam int HFP  = 2;
  localparam int VS   = 2;
  localparam int VBP  = 2;
  localparam int VV   = 5;
  localparam int VFP  = 2;
  localparam int HT   = HS + HBP + HV + HFP;
  localparam int VT   = VS + VBP + VV + VFP;
  localparam int FPIX = HT * VT;
  localparam int FCLK = FPIX * CD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hCount, vCount;
  logic        bright, pix_en, frame_tick;
  logic [11:0] rgb_in = 12'h000;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        hSync, vSync;

  int total = 0;
  int bad   = 0;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_SYNC(HS), .H_BP(HBP), .H_VIS(HV), .H_FP(HFP),
    .V_SYNC(VS), .V_BP(VBP), .V_VIS(VV), .V_FP(VFP)
  ) dut (
    .clk(clk), .rst(rst),
    .hCount(hCount), .vCount(vCount),
    .bright(bright), .pix_en(pix_en), .frame_tick(frame_tick),
    .rgb_in(rgb_in),
    .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .hSync(hSync), .vSync(vSync)
  );

  always #5 clk = ~clk;

  localparam logic [36:0] RST_VEC = {10'd0, 10'd0, 3'b000, 12'h000, 2'b11};

  typedef struct {
    int   h;
    int   v;
    logic b;
  } vec_t;

  function automatic logic [36:0] dut_vec();
    return {hCount, vCount, bright, pix_en, frame_tick,
            vgaR, vgaG, vgaB, hSync, vSync};
  endfunction

  function automatic logic vis(int h, int v);
    return (h >= HS + HBP) && (h < HS + HBP + HV) &&
           (v >= VS + VBP) && (v < VS + VBP + VV);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected outputs derived from edges elapsed since reset release.
  task automatic run_model(input int n, output int nticks,
                           output int first_tick, output int bcnt);
    int t, p, q, eh, ev, hlow, vlow;
    logic [11:0] cur, prv, col;
    logic ep, etk, ehs, evs, hs_prev, vs_prev;
    logic [36:0] ex;
    t = 0; hlow = 0; vlow = 0;
    nticks = 0; first_tick = -1; bcnt = 0;
    hs_prev = 1'b1; vs_prev = 1'b1;
    cur = 12'($urandom); prv = 12'h000;
    rgb_in = cur;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      t++;
      #1;
      p = t / CD;
      if (t % CD == 0) prv = cur;
      eh  = p % HT;
      ev  = (p / HT) % VT;
      ep  = (t % CD == CD - 1);
      etk = (t % CD == 0) && (p % FPIX == 0);
      if (p == 0) begin
        col = 12'h000; ehs = 1'b1; evs = 1'b1;
      end else begin
        q   = p - 1;
        col = vis(q % HT, (q / HT) % VT) ? prv : 12'h000;
        ehs = !((q % HT) < HS);
        evs = !(((q / HT) % VT) < VS);
      end
      ex = {10'(eh), 10'(ev), vis(eh, ev), ep, etk, col, ehs, evs};
      chk("cycle", 64'(dut_vec()), 64'(ex));
      if (t == CD) chk("first_px_h", 64'(hCount), 64'd1);
      if (!hSync) hlow++;
      if (hSync && !hs_prev) begin
        chk("hsync_width", 64'(hlow), 64'(HS * CD));
        hlow = 0;
      end
      if (!vSync) vlow++;
      if (vSync && !vs_prev) begin
        chk("vsync_width", 64'(vlow), 64'(VS * HT * CD));
        vlow = 0;
      end
      hs_prev = hSync;
      vs_prev = vSync;
      if (frame_tick) begin
        nticks++;
        if (first_tick < 0) first_tick = t;
      end
      if (t <= FCLK && pix_en && bright) bcnt++;
      if (t % CD == 0) begin
        cur = 12'($urandom);
        rgb_in = cur;
      end
    end
  endtask

  task automatic goto_pos(input int h, input int v, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 2 * FCLK; k++) begin
      @(posedge clk);
      #1;
      if (hCount == 10'(h) && vCount == 10'(v)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL goto_timeout: got no (%0d,%0d) want reached", h, v);
    end
  endtask

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[8];
    int nt, ft, bc;
    logic ok;

    tbl[0] = '{7, 4, 1'b1};
    tbl[1] = '{14, 8, 1'b1};
    tbl[2] = '{6, 4, 1'b0};
    tbl[3] = '{15, 4, 1'b0};
    tbl[4] = '{7, 3, 1'b0};
    tbl[5] = '{7, 9, 1'b0};
    tbl[6] = '{10, 6, 1'b1};
    tbl[7] = '{0, 0, 1'b0};

    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("reset_vals", 64'(dut_vec()), 64'(RST_VEC));

    @(negedge clk);
    rst = 1'b1;
    run_model(2 * FCLK + 10, nt, ft, bc);
    chk("tick_count", 64'(nt), 64'd2);
    chk("tick_first", 64'(ft), 64'(FCLK));
    chk("bright_pixels", 64'(bc), 64'(HV * VV));

    rgb_in = 12'h0F0;
    foreach (tbl[i]) begin
      goto_pos(tbl[i].h, tbl[i].v, ok);
      if (ok) begin
        chk("tbl_bright", 64'(bright), 64'(tbl[i].b));
        for (int k = 0; k < CD; k++) begin
          if (pix_en) break;
          @(posedge clk);
          #1;
        end
        @(posedge clk);
        #1;
        chk("tbl_pins", 64'({vgaR, vgaG, vgaB, hSync}),
            64'({(tbl[i].b ? 12'h0F0 : 12'h000), tbl[i].h >= HS}));
      end
    end

    goto_pos(10, 5, ok);
    if (ok) begin
      #2;
      rst = 1'b0;
      #1;
      chk("async_reset", 64'(dut_vec()), 64'(RST_VEC));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 64'(dut_vec()), 64'(RST_VEC));
    @(negedge clk);
    rst = 1'b1;
    run_model(FCLK + 6, nt, ft, bc);
    chk("restart_tick_count", 64'(nt), 64'd1);
    chk("restart_tick_first", 64'(ft), 64'(FCLK));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel timing generator that drives the `hCount`, `vCount` and `bright` inputs consumed by the game state machine and block renderer. It also takes their 12-bit `rgb` result back and presents blanked, sync-aligned colour and sync signals to the VGA pins. It is a 640x480@60 Hz generator running from the 100 MHz board clock with an internal pixel-enable divider. It also emits a once-per-frame tick that game logic uses to step object motion.

## Interface
- `CLK_DIV`, 4: board clocks per pixel (minimum 2).
- `H_SYNC`, 96: hsync pulse width in pixels.
- `H_BP`, 48: horizontal back porch in pixels.
- `H_VIS`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch in pixels.
- `V_SYNC`, 2: vsync pulse width in lines.
- `V_BP`, 33: vertical back porch in lines.
- `V_VIS`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch in lines.
- `clk` in 1: board clock. This is the only clock.
- `rst` in 1: reset, asynchronous, active-low (asserted when 0).
- `hCount` out 10: current pixel column. Runs 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_VIS+H_FP = 800.
- `vCount` out 10: current line. Runs 0..V_TOTAL-1, where V_TOTAL = 525.
- `bright` out 1: current (`hCount`, `vCount`) is inside the visible window.
- `pix_en` out 1: one-`clk` pixel strobe.
- `frame_tick` out 1: one-`clk` pulse per frame.
- `rgb_in` in 12: colour for the current `hCount`/`vCount`, format {R[3:0],G[3:0],B[3:0]}, combinational from the renderer.
- `vgaR`, `vgaG`, `vgaB` out 4 each: registered pin colour.
- `hSync`, `vSync` out 1: registered pin syncs, active-low.

## Operation
- Divider `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_en` = (`div` == CLK_DIV-1), decoded combinationally from the register.
- On each edge with `pix_en`=1:
  - `hCount` increments. At H_TOTAL-1 it wraps to 0 and `vCount` increments.
  - `vCount` wraps from V_TOTAL-1 to 0 only when `hCount` also wraps.
  - Both counters hold on all other edges.
- `bright` is asserted when both of these hold:
  - H_SYNC+H_BP ≤ `hCount` ≤ H_SYNC+H_BP+H_VIS-1 (144..783)
  - V_SYNC+V_BP ≤ `vCount` ≤ V_SYNC+V_BP+V_VIS-1 (35..514)
  - Decoded from the counter registers, so it has zero latency relative to the counters.
- Sync region: raw hsync is active for `hCount` < H_SYNC. Raw vsync is active for `vCount` < V_SYNC.
- Output stage, captured on each `pix_en` edge:
  - `vgaR`/`vgaG`/`vgaB` take `rgb_in` when `bright`=1, else 0.
  - `hSync` and `vSync` take the raw sync of the same pixel (low = active).
  - Colour and sync on the pins are therefore mutually aligned and lag the counters by one pixel.
- `frame_tick` is a registered pulse. It is high for exactly one `clk` cycle, the cycle right after the edge at which the counters go from (799,524) to (0,0).
- All counter arithmetic is unsigned 10-bit. H_TOTAL and V_TOTAL must both be ≤ 1024.

## Timing
- Reset values (while `rst`=0):
  - `div`=0, `hCount`=0, `vCount`=0.
  - `bright`=0.
  - `vgaR`/`vgaG`/`vgaB`=0.
  - `hSync`=1, `vSync`=1.
  - `frame_tick`=0.
  - `pix_en`=0.
- After `rst` deasserts:
  - The first `pix_en` cycle is the CLK_DIV-th `clk` cycle.
  - On that edge `hCount` becomes 1, and `hSync`/`vSync` go to 0 (pixel (0,0) is in both sync regions).
- Periods with default parameters:
  - Pixel: 4 `clk`.
  - Line: 3200 `clk`.
  - Frame: 1,680,000 `clk`.
  - hsync low: 384 `clk`.
  - vsync low: 6400 `clk`.
- Reset asserted mid-frame forces all reset values immediately, with no wait for `clk`. On release, the frame restarts at (0,0).
  - `frame_tick` is not issued for the restart, only for the next wrap from (799,524).
- `rgb_in` must settle within one `clk` of a counter change. It is sampled only on `pix_en` edges.

## Test plan
- Reset: hold `rst`=0 for 10 `clk` → all outputs at their reset values. Release → `hCount` is 1 exactly 4 `clk` later, `pix_en` is high once every 4 `clk`.
- Horizontal: measure over 3 lines → `hSync` low for 384 `clk` of every 3200. `hCount` wraps 799→0 and `vCount` increments at the same edge.
- Vertical and tick: run 2 frames → `vSync` low for 6400 `clk`, `frame_tick` pulses once per 1,680,000 `clk`, each pulse 1 `clk` wide.
- Visible window: `bright` is 1 exactly at (144,35) and (783,514). It is 0 at (143,35), (784,35), (144,34) and (144,515). Total `bright` pixels per frame = 307,200.
- Blanking: drive `rgb_in`=12'hFFF constantly → pins show F/F/F only on the pixel after each `bright` pixel and 0 elsewhere. Change `rgb_in` to 12'h0F0 → `vgaG`=F, `vgaR`=`vgaB`=0 one pixel later.
- Mid-frame reset: assert `rst`=0 at (400,200) → outputs reset asynchronously within the same cycle. After release, timing restarts from (0,0), and the first `frame_tick` arrives 1,680,000 `clk` after release.
